// File: rtl/mult_issue_ctrl_pkg.sv
// Shared types and constants for the multiplier issue controller.
// Holds pipeline depth, result-type encodings and the scoreboard entry.
package mult_issue_ctrl_pkg;

    localparam int MULT_PPL_STAGE = 4;

    typedef enum logic [1:0] {
        MT_LOW = 2'b00,
        MT_SXS = 2'b01,
        MT_SXU = 2'b10,
        MT_UXU = 2'b11
    } mult_type_e;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        mult_type_e typ;
    } sb_entry_t;

endpackage

// File: rtl/mult_issue_ctrl_if.sv
// Decode-side issue request, multiplier issue and writeback bundle.
// master = decode/issue side, slave = issue controller.
interface mult_issue_ctrl_if;

    logic       issue_valid;
    logic       issue_is_mult;
    logic [1:0] issue_type;
    logic [4:0] issue_rd;
    logic [4:0] issue_rs1;
    logic [4:0] issue_rs2;
    logic       flush;
    logic       drain_req;

    logic       issue_stall;
    logic       mult_use;
    logic [4:0] mult_rd;
    logic [1:0] mult_type;
    logic       wb_mult_valid;
    logic [4:0] wb_mult_rd;
    logic [1:0] wb_mult_type;
    logic       fwd_rs1;
    logic       fwd_rs2;

    modport master (
        output issue_valid, issue_is_mult, issue_type,
        output issue_rd, issue_rs1, issue_rs2,
        output flush, drain_req,
        input  issue_stall, mult_use, mult_rd, mult_type,
        input  wb_mult_valid, wb_mult_rd, wb_mult_type,
        input  fwd_rs1, fwd_rs2
    );

    modport slave (
        input  issue_valid, issue_is_mult, issue_type,
        input  issue_rd, issue_rs1, issue_rs2,
        input  flush, drain_req,
        output issue_stall, mult_use, mult_rd, mult_type,
        output wb_mult_valid, wb_mult_rd, wb_mult_type,
        output fwd_rs1, fwd_rs2
    );

endinterface

// File: rtl/mult_issue_ctrl_scoreboard.sv
// In-flight multiply tracker: fixed-latency shift register of {valid,rd,type}
// with per-stage register comparators for both sources and the destination.
module mult_issue_ctrl_scoreboard
    import mult_issue_ctrl_pkg::*;
#(
    parameter int STAGES = MULT_PPL_STAGE
) (
    input  logic              clk,
    input  logic              rst,
    input  sb_entry_t         load,
    input  logic [4:0]        rs1,
    input  logic [4:0]        rs2,
    input  logic [4:0]        rd,
    output sb_entry_t         wb,
    output logic [STAGES-1:0] busy,
    output logic [STAGES-1:0] match_rs1,
    output logic [STAGES-1:0] match_rs2,
    output logic [STAGES-2:0] match_rd
);

    sb_entry_t stage_q [STAGES];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < STAGES; i++)
                stage_q[i] <= '0;
        end else begin
            stage_q[0] <= load;
            for (int i = 1; i < STAGES; i++)
                stage_q[i] <= stage_q[i-1];
        end
    end

    // x0 never matches: it is neither read nor written
    always_comb begin
        busy      = '0;
        match_rs1 = '0;
        match_rs2 = '0;
        match_rd  = '0;
        for (int i = 0; i < STAGES; i++) begin
            busy[i]      = stage_q[i].valid;
            match_rs1[i] = stage_q[i].valid && rs1 != 5'd0
                           && stage_q[i].rd == rs1;
            match_rs2[i] = stage_q[i].valid && rs2 != 5'd0
                           && stage_q[i].rd == rs2;
        end
        for (int i = 0; i < STAGES-1; i++)
            match_rd[i] = stage_q[i].valid && rd != 5'd0
                          && stage_q[i].rd == rd;
    end

    assign wb = stage_q[STAGES-1];

endmodule

// File: rtl/mult_issue_ctrl.sv
// Issue/hazard controller for the pipelined multiplier: RAW/WAW/WB-port
// stalls, last-stage forwarding, fence drain and in-flight accounting.
module mult_issue_ctrl
    import mult_issue_ctrl_pkg::*;
#(
    parameter int STAGES = MULT_PPL_STAGE,
    parameter int WB_LAT = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    mult_issue_ctrl_if.slave            bus,
    output logic [STAGES-1:0]           busy,
    output logic [$clog2(STAGES+1)-1:0] inflight,
    output logic                        drained
);

    localparam int CW = $clog2(STAGES+1);

    if (STAGES < 2 || WB_LAT < 1 || WB_LAT > STAGES-1) begin : g_bad_cfg
        $error("mult_issue_ctrl: bad STAGES/WB_LAT");
    end

    sb_entry_t         load;
    sb_entry_t         wb;
    logic [STAGES-1:0] m_rs1;
    logic [STAGES-1:0] m_rs2;
    logic [STAGES-2:0] m_rd;
    logic [CW-1:0]     cnt_q;

    logic is_write;
    logic is_noop;
    logic raw_rs1;
    logic raw_rs2;
    logic waw;
    logic wb_port;
    logic drain_blk;

    mult_issue_ctrl_scoreboard #(.STAGES(STAGES)) u_sb (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .rs1       (bus.issue_rs1),
        .rs2       (bus.issue_rs2),
        .rd        (bus.issue_rd),
        .wb        (wb),
        .busy      (busy),
        .match_rs1 (m_rs1),
        .match_rs2 (m_rs2),
        .match_rd  (m_rd)
    );

    assign is_write  = bus.issue_rd != 5'd0;
    assign is_noop   = bus.issue_is_mult && !is_write;
    assign raw_rs1   = |m_rs1[STAGES-2:0];
    assign raw_rs2   = |m_rs2[STAGES-2:0];
    assign waw       = |m_rd;
    // a short-latency writer would land on the mult result's WB slot
    assign wb_port   = !bus.issue_is_mult && is_write
                       && busy[STAGES-1-WB_LAT];
    assign drain_blk = bus.issue_is_mult && bus.drain_req;

    assign bus.issue_stall = bus.issue_valid && !is_noop
                             && (raw_rs1 || raw_rs2 || waw
                                 || wb_port || drain_blk);

    assign bus.mult_use = bus.issue_valid && bus.issue_is_mult
                          && is_write && !bus.issue_stall
                          && !bus.flush;

    assign bus.mult_rd   = bus.mult_use ? bus.issue_rd : 5'd0;
    assign bus.mult_type = bus.mult_use ? bus.issue_type : 2'd0;

    assign bus.fwd_rs1 = bus.issue_valid && m_rs1[STAGES-1] && !raw_rs1;
    assign bus.fwd_rs2 = bus.issue_valid && m_rs2[STAGES-1] && !raw_rs2;

    always_comb begin
        load       = '0;
        load.valid = bus.mult_use;
        load.rd    = bus.mult_rd;
        load.typ   = mult_type_e'(bus.mult_type);
    end

    assign bus.wb_mult_valid = wb.valid;
    assign bus.wb_mult_rd    = wb.rd;
    assign bus.wb_mult_type  = wb.typ;

    always_ff @(posedge clk) begin
        if (rst)
            cnt_q <= '0;
        else if (bus.mult_use && !wb.valid)
            cnt_q <= cnt_q + CW'(1);
        else if (!bus.mult_use && wb.valid)
            cnt_q <= cnt_q - CW'(1);
    end

    assign inflight = cnt_q;
    assign drained  = cnt_q == '0 && !bus.mult_use;

endmodule

// File: tb/tb_mult_issue_ctrl.sv
// Bench for mult_issue_ctrl: directed scenarios plus randomized traffic,
// checked every cycle against a cycle-indexed issue-history model.
module tb_mult_issue_ctrl;
    import mult_issue_ctrl_pkg::*;

    localparam int S    = 4;
    localparam int WL   = 1;
    localparam int MAXC = 4000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mult_issue_ctrl_if bus();
    logic [S-1:0] busy;
    logic [2:0]   inflight;
    logic         drained;

    mult_issue_ctrl #(.STAGES(S), .WB_LAT(WL)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .busy     (busy),
        .inflight (inflight),
        .drained  (drained)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int last_rst = -1;

    // history of accepted multiplies, indexed by acceptance cycle
    bit         acc_v  [MAXC];
    logic [4:0] acc_rd [MAXC];
    logic [1:0] acc_ty [MAXC];

    bit e_stall;
    bit e_use;

    task automatic chk(input string n, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0d want=%0d", n, cyc, act, exp);
        end
    endtask

    // op accepted in cycle t sits in stage (c-1-t) during cycle c,
    // unless a reset edge happened at or after its acceptance
    function automatic bit st_v(input int k);
        int t;
        t = cyc - 1 - k;
        return t >= 0 && t > last_rst && acc_v[t];
    endfunction

    function automatic logic [4:0] st_rd(input int k);
        return acc_rd[cyc - 1 - k];
    endfunction

    task automatic step(input bit r, input bit v, input bit m,
                        input logic [1:0] ty, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2,
                        input bit fl, input bit dr);
        int infl;
        bit raw1, raw2, f1, f2, waw, wbp, noop;
        int e_busy;
        bit wv;
        logic [4:0] wrd;
        logic [1:0] wty;
        @(posedge clk);
        #1;
        rst               = r;
        bus.issue_valid   = v;
        bus.issue_is_mult = m;
        bus.issue_type    = ty;
        bus.issue_rd      = rd;
        bus.issue_rs1     = rs1;
        bus.issue_rs2     = rs2;
        bus.flush         = fl;
        bus.drain_req     = dr;
        #1;
        infl = 0; e_busy = 0;
        raw1 = 0; raw2 = 0; f1 = 0; f2 = 0; waw = 0;
        for (int k = 0; k < S; k++) begin
            if (st_v(k)) begin
                infl++;
                e_busy |= (1 << k);
                if (k < S-1) begin
                    if (rs1 != 0 && st_rd(k) == rs1) raw1 = 1;
                    if (rs2 != 0 && st_rd(k) == rs2) raw2 = 1;
                    if (rd != 0 && st_rd(k) == rd) waw = 1;
                end else begin
                    if (rs1 != 0 && st_rd(k) == rs1) f1 = 1;
                    if (rs2 != 0 && st_rd(k) == rs2) f2 = 1;
                end
            end
        end
        f1   = v && f1 && !raw1;
        f2   = v && f2 && !raw2;
        wbp  = !m && rd != 0 && st_v(S-1-WL);
        noop = m && rd == 0;
        e_stall = v && !noop && (raw1 || raw2 || waw || wbp || (m && dr));
        e_use   = v && m && rd != 0 && !e_stall && !fl;
        wv  = st_v(S-1);
        wrd = wv ? st_rd(S-1) : 5'd0;
        wty = wv ? acc_ty[cyc-S] : 2'd0;
        chk("stall",    bus.issue_stall, e_stall);
        chk("use",      bus.mult_use, e_use);
        chk("mult_rd",  bus.mult_rd, e_use ? rd : 0);
        chk("mult_ty",  bus.mult_type, e_use ? ty : 0);
        chk("wb_valid", bus.wb_mult_valid, wv);
        chk("wb_rd",    bus.wb_mult_rd, wrd);
        chk("wb_type",  bus.wb_mult_type, wty);
        chk("fwd1",     bus.fwd_rs1, f1);
        chk("fwd2",     bus.fwd_rs2, f2);
        chk("busy",     busy, e_busy);
        chk("inflight", inflight, infl);
        chk("drained",  drained, infl == 0 && !e_use);
        acc_v[cyc]  = e_use;
        acc_rd[cyc] = rd;
        acc_ty[cyc] = ty;
        if (r) last_rst = cyc;
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic mul(input logic [4:0] rd, input logic [1:0] ty);
        step(0, 1, 1, ty, rd, 0, 0, 0, 0);
    endtask

    bit         h_v, h_m, h_fl, h_dr, h_r;
    logic [1:0] h_ty;
    logic [4:0] h_rd, h_rs1, h_rs2;
    bit         held;

    initial begin
        bus.issue_valid = 0; bus.issue_is_mult = 0; bus.issue_type = 0;
        bus.issue_rd = 0; bus.issue_rs1 = 0; bus.issue_rs2 = 0;
        bus.flush = 0; bus.drain_req = 0;
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(1);
        chk("rst_busy", busy, 0);
        chk("rst_inflight", inflight, 0);
        chk("rst_drained", drained, 1);
        chk("rst_wb", bus.wb_mult_valid, 0);
        chk("rst_use", bus.mult_use, 0);

        // mult rd5 followed by a dependent add every cycle
        mul(5, 2'b01);
        chk("a_use", bus.mult_use, 1);
        chk("a_rd", bus.mult_rd, 5);
        step(0, 1, 0, 0, 6, 5, 0, 0, 0);
        chk("a_busy0", busy[0], 1);
        chk("a_stall1", bus.issue_stall, 1);
        step(0, 1, 0, 0, 6, 5, 0, 0, 0);
        chk("a_stall2", bus.issue_stall, 1);
        step(0, 1, 0, 0, 6, 5, 0, 0, 0);
        chk("a_stall3", bus.issue_stall, 1);
        step(0, 1, 0, 0, 6, 5, 0, 0, 0);
        chk("a_stall4", bus.issue_stall, 0);
        chk("a_fwd", bus.fwd_rs1, 1);
        chk("a_wbv", bus.wb_mult_valid, 1);
        chk("a_wbrd", bus.wb_mult_rd, 5);
        idle(1);
        chk("a_wbgone", bus.wb_mult_valid, 0);

        // writeback-port collision for a short-latency writer
        mul(7, 2'b00);
        idle(2);
        step(0, 1, 0, 0, 9, 0, 0, 0, 0);
        chk("b_stall", bus.issue_stall, 1);
        step(0, 1, 0, 0, 9, 0, 0, 0, 0);
        chk("b_go", bus.issue_stall, 0);
        idle(2);

        // four back-to-back mults, then an rd=0 mult
        for (int i = 1; i <= 4; i++) begin
            mul(5'(i), 2'(i - 1));
            chk("c_use", bus.mult_use, 1);
        end
        step(0, 1, 1, 0, 0, 0, 0, 0, 0);
        chk("c_inflight", inflight, 4);
        chk("c_noop_use", bus.mult_use, 0);
        chk("c_noop_stall", bus.issue_stall, 0);
        chk("c_wb1", bus.wb_mult_rd, 1);
        idle(1);
        chk("c_wb2", bus.wb_mult_rd, 2);
        idle(1);
        chk("c_wb3", bus.wb_mult_rd, 3);
        idle(1);
        chk("c_wb4", bus.wb_mult_rd, 4);
        chk("c_wb4t", bus.wb_mult_type, 3);
        idle(1);

        // drain with two in flight
        mul(1, 0);
        mul(2, 0);
        step(0, 1, 1, 0, 3, 0, 0, 0, 1);
        chk("d_stall", bus.issue_stall, 1);
        step(0, 1, 1, 0, 3, 0, 0, 0, 1);
        step(0, 1, 1, 0, 3, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1);
        chk("d_notdrained", drained, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1);
        chk("d_drained", drained, 1);

        // flush, then reset with an op in flight
        step(0, 1, 1, 0, 8, 0, 0, 1, 0);
        chk("e_flush", bus.mult_use, 0);
        mul(3, 2);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(1);
        chk("e_rst_inflight", inflight, 0);
        idle(4);

        held = 0;
        h_dr = 0;
        for (int i = 0; i < 2500; i++) begin
            h_r = $urandom_range(0, 99) == 0;
            if (!held) begin
                h_v   = $urandom_range(0, 9) < 8;
                h_m   = $urandom_range(0, 1);
                h_ty  = 2'($urandom_range(0, 3));
                h_rd  = 5'($urandom_range(0, 7));
                h_rs1 = 5'($urandom_range(0, 7));
                h_rs2 = 5'($urandom_range(0, 7));
            end
            h_fl = $urandom_range(0, 9) == 0;
            if ($urandom_range(0, 19) == 0) h_dr = !h_dr;
            if (h_r) h_v = 0;
            step(h_r, h_v, h_m, h_ty, h_rd, h_rs1, h_rs2, h_fl, h_dr);
            held = e_stall && !h_fl;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
